line_window_buffer: RTL and testbench

- Streaming 3x3 neighbourhood generator for the image-processing path.
- Accepts one pixel per `pix_valid` strobe in raster order from the host receive path and holds the two previous image rows in line buffers.
- Presents a registered 3x3 window plus qualifiers to the systolic window array. Input order is MATLAB -> FPGA, row-major.
- Forces the window to black when the pixel-count enable `num_pix_ok` is low, so border pixels come back black.

---
 rtl/img_pkg.sv | 23 ++
 rtl/line_buffer.sv | 25 ++
 rtl/line_window_buffer.sv | 148 ++++++++++++++
 tb/tb_line_window_buffer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared image-path constants: default geometry, 3x3 window element offsets
// and the fill/stream state encoding used by the window generator.
package img_pkg;

   localparam int PIX_W_DEF = 8;
   localparam int IMG_W_DEF = 100;
   localparam int IMG_H_DEF = 100;

   // Element index (3r+c) inside the packed window; r=0 is the oldest row.
   localparam int W00 = 0;
   localparam int W01 = 1;
   localparam int W02 = 2;
   localparam int W10 = 3;
   localparam int W11 = 4;
   localparam int W12 = 5;
   localparam int W20 = 6;
   localparam int W21 = 7;
   localparam int W22 = 8;

   localparam logic [0:0] ST_FILL   = 1'b0;
   localparam logic [0:0] ST_STREAM = 1'b1;

endpackage

// File: rtl/line_buffer.sv
// One image row of storage: single address, combinational read of the old
// word in the same cycle that the new word is written.
module line_buffer #(
   parameter int DEPTH = 100,
   parameter int WIDTH = 8
) (
   input  logic                                       clk,
   input  logic                                       we,
   input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] addr,
   input  logic [WIDTH-1:0]                           din,
   output logic [WIDTH-1:0]                           dout
);

   logic [WIDTH-1:0] mem [DEPTH];

   // No reset: contents are rewritten by the fill rows before they are used.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= din;
      end
   end

   assign dout = mem[addr];

endmodule

// File: rtl/line_window_buffer.sv
// Streaming 3x3 neighbourhood generator: two line buffers feed a column shift
// register, and a registered window with qualifiers is presented downstream.
module line_window_buffer
   import img_pkg::*;
#(
   parameter int IMG_W = IMG_W_DEF,
   parameter int IMG_H = IMG_H_DEF,
   parameter int PIX_W = PIX_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [PIX_W-1:0]   pix_in,
   input  logic               pix_valid,
   input  logic               num_pix_ok,
   output logic [9*PIX_W-1:0] win,
   output logic               win_valid,
   output logic               frame_done,
   output logic [0:0]         fsm_state_o
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [CW-1:0] COL_TWO  = CW'(2);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [RW-1:0] ROW_ONE  = RW'(1);

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [0:0]    state_q, state_d;

   logic [PIX_W-1:0] t1, t2;

   // Window columns, each indexed by row: [0]=top (oldest), [2]=current row.
   logic [2:0][PIX_W-1:0] c0_q, c0_d;
   logic [2:0][PIX_W-1:0] c1_q, c1_d;
   logic [2:0][PIX_W-1:0] c2_q, c2_d;

   logic [9*PIX_W-1:0] win_q, win_d;
   logic               win_valid_q, win_valid_d;
   logic               frame_done_q, frame_done_d;

   logic last_col, last_row, in_stream;

   line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
      .clk  (clk),
      .we   (pix_valid),
      .addr (col_q),
      .din  (pix_in),
      .dout (t1)
   );

   line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb2 (
      .clk  (clk),
      .we   (pix_valid),
      .addr (col_q),
      .din  (t1),
      .dout (t2)
   );

   assign last_col  = (col_q == COL_LAST);
   assign last_row  = (row_q == ROW_LAST);
   assign in_stream = (state_q == ST_STREAM);

   always_comb begin
      col_d   = col_q;
      row_d   = row_q;
      state_d = state_q;
      if (pix_valid) begin
         if (last_col) begin
            col_d = '0;
            row_d = last_row ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
         case (state_q)
            ST_FILL:   if (last_col && row_q == ROW_ONE) state_d = ST_STREAM;
            ST_STREAM: if (last_col && last_row)         state_d = ST_FILL;
            default:   state_d = ST_FILL;
         endcase
      end
   end

   always_comb begin
      c0_d = c0_q;
      c1_d = c1_q;
      c2_d = c2_q;
      if (pix_valid) begin
         c0_d = c1_q;
         c1_d = c2_q;
         c2_d = {pix_in, t1, t2};
      end
   end

   // The output window is the post-shift view; black forcing only masks it.
   always_comb begin
      win_d = win_q;
      if (pix_valid) begin
         if (num_pix_ok) begin
            win_d[PIX_W*W00 +: PIX_W] = c1_q[0];
            win_d[PIX_W*W01 +: PIX_W] = c2_q[0];
            win_d[PIX_W*W02 +: PIX_W] = t2;
            win_d[PIX_W*W10 +: PIX_W] = c1_q[1];
            win_d[PIX_W*W11 +: PIX_W] = c2_q[1];
            win_d[PIX_W*W12 +: PIX_W] = t1;
            win_d[PIX_W*W20 +: PIX_W] = c1_q[2];
            win_d[PIX_W*W21 +: PIX_W] = c2_q[2];
            win_d[PIX_W*W22 +: PIX_W] = pix_in;
         end else begin
            win_d = '0;
         end
      end
   end

   // Windows never straddle the row wrap: the first two columns are skipped.
   assign win_valid_d  = pix_valid && in_stream && (col_q >= COL_TWO);
   assign frame_done_d = pix_valid && in_stream && last_col && last_row;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col_q        <= '0;
         row_q        <= '0;
         state_q      <= ST_FILL;
         c0_q         <= '0;
         c1_q         <= '0;
         c2_q         <= '0;
         win_q        <= '0;
         win_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         state_q      <= state_d;
         c0_q         <= c0_d;
         c1_q         <= c1_d;
         c2_q         <= c2_d;
         win_q        <= win_d;
         win_valid_q  <= win_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign win         = win_q;
   assign win_valid   = win_valid_q;
   assign frame_done  = frame_done_q;
   assign fsm_state_o = state_q;

endmodule

// File: tb/tb_line_window_buffer.sv
// Directed bench for line_window_buffer on a 5x4 image of 8-bit pixels.
module tb_line_window_buffer;

   localparam int IMG_W = 5;
   localparam int IMG_H = 4;
   localparam int PIX_W = 8;
   localparam int NPIX  = IMG_W * IMG_H;
   localparam int WW    = 9 * PIX_W;

   logic            clk;
   logic            reset;
   logic [PIX_W-1:0] pix_in;
   logic            pix_valid;
   logic            num_pix_ok;
   logic [WW-1:0]   win;
   logic            win_valid;
   logic            frame_done;
   logic [0:0]      fsm_state_o;

   int n_checks;
   int n_fail;
   int pulses;
   logic [WW-1:0] exp_q[$];
   logic [WW-1:0] obs_win [NPIX];
   logic          obs_valid [NPIX];

   line_window_buffer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .pix_in      (pix_in),
      .pix_valid   (pix_valid),
      .num_pix_ok  (num_pix_ok),
      .win         (win),
      .win_valid   (win_valid),
      .frame_done  (frame_done),
      .fsm_state_o (fsm_state_o)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [WW-1:0] pack9(input int a, input int b, input int c,
                                           input int d, input int e, input int f,
                                           input int g, input int h, input int i);
      return {8'(i), 8'(h), 8'(g), 8'(f), 8'(e), 8'(d), 8'(c), 8'(b), 8'(a)};
   endfunction

   // Window centred one row and one column behind raster index idx.
   function automatic logic [WW-1:0] exp_win(input int base, input int idx);
      logic [WW-1:0] w;
      int r;
      int c;
      r = idx / IMG_W;
      c = idx % IMG_W;
      w = '0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            w[PIX_W*(3*i+j) +: PIX_W] = 8'(base + (r - 2 + i) * IMG_W + (c - 2 + j));
      return w;
   endfunction

   function automatic bit exp_valid(input int idx);
      return (idx / IMG_W >= 2) && (idx % IMG_W >= 2);
   endfunction

   // driver tasks
   task automatic send_pix(input logic [PIX_W-1:0] v, input logic ok);
      pix_valid  = 1'b1;
      pix_in     = v;
      num_pix_ok = ok;
      @(posedge clk);
      #1;
      pix_valid  = 1'b0;
      num_pix_ok = 1'b1;
   endtask

   task automatic idle_cycle();
      pix_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input int base, input int npix, input int black_idx, input bit gaps);
      logic [WW-1:0] e;
      bit ev;
      int ngap;
      pulses = 0;
      for (int idx = 0; idx < npix; idx++) begin
         ev = exp_valid(idx);
         e  = (idx == black_idx) ? '0 : exp_win(base, idx);
         if (ev) exp_q.push_back(e);
         send_pix(8'(base + idx), idx != black_idx);
         obs_win[idx]   = win;
         obs_valid[idx] = win_valid;
         check_eq($sformatf("win_valid@%0d", base + idx), win_valid, ev);
         check_eq($sformatf("frame_done@%0d", base + idx), frame_done, idx == NPIX - 1);
         if (win_valid) begin
            pulses++;
            if (exp_q.size() > 0) check_eq($sformatf("win@%0d", base + idx), win, exp_q.pop_front());
            else check_eq($sformatf("unexpected_win@%0d", base + idx), win_valid, 1'b0);
         end
         if (gaps) begin
            ngap = $urandom_range(4, 1);
            for (int g = 0; g < ngap; g++) begin
               idle_cycle();
               check_eq($sformatf("gap_valid@%0d", base + idx), win_valid, 1'b0);
               check_eq($sformatf("gap_done@%0d", base + idx), frame_done, 1'b0);
               if (ev) check_eq($sformatf("gap_hold@%0d", base + idx), win, e);
            end
         end
      end
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      reset      = 1'b1;
      pix_in     = '0;
      pix_valid  = 1'b0;
      num_pix_ok = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset_win", win, '0);
      check_eq("reset_valid", win_valid, 1'b0);
      check_eq("reset_done", frame_done, 1'b0);
      check_eq("reset_state", fsm_state_o, 1'b0);
      reset = 1'b0;
      idle_cycle();

      // fill, first window and full frame
      run_frame(0, NPIX, -1, 0);
      check_eq("fill_no_valid_11", obs_valid[11], 1'b0);
      check_eq("first_valid_12", obs_valid[12], 1'b1);
      check_eq("first_win_12", obs_win[12], pack9(0, 1, 2, 5, 6, 7, 10, 11, 12));
      check_eq("last_win_19", obs_win[19], pack9(7, 8, 9, 12, 13, 14, 17, 18, 19));
      check_eq("pulses_full", pulses, 6);
      check_eq("state_after_frame", fsm_state_o, 1'b0);

      // frame wrap straight into the next frame
      run_frame(20, NPIX, -1, 0);
      check_eq("wrap_first_win", obs_win[12], pack9(20, 21, 22, 25, 26, 27, 30, 31, 32));
      check_eq("pulses_wrap", pulses, 6);

      // black forcing on index 13
      run_frame(0, NPIX, 13, 0);
      check_eq("black_valid_13", obs_valid[13], 1'b1);
      check_eq("black_win_13", obs_win[13], '0);
      check_eq("after_black_14", obs_win[14], pack9(2, 3, 4, 7, 8, 9, 12, 13, 14));

      // random idle gaps
      run_frame(0, NPIX, -1, 1);
      check_eq("pulses_gaps", pulses, 6);

      // reset mid-frame after index 16
      run_frame(0, 17, -1, 0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_eq("midreset_win", win, '0);
      check_eq("midreset_valid", win_valid, 1'b0);
      check_eq("midreset_state", fsm_state_o, 1'b0);
      reset = 1'b0;
      exp_q.delete();
      idle_cycle();
      run_frame(100, NPIX, -1, 0);
      check_eq("post_reset_win_112", obs_win[12], pack9(100, 101, 102, 105, 106, 107, 110, 111, 112));
      check_eq("pulses_post_reset", pulses, 6);

      check_eq("exp_q_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
